instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_if.sv | 33 +++
 rtl/instr_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: control strobes, jump request, program-memory
// port and decoded-instruction outputs of the instruction sequencer.
interface instr_sequencer_if;
  logic        Fetch;
  logic        Decode;
  logic        Execute;
  logic        jump_en;
  logic [15:0] jump_addr;
  logic [7:0]  rom_data;
  logic [15:0] rom_addr;
  logic [15:0] pc;
  logic [7:0]  Opcode;
  logic [7:0]  operand1;
  logic [7:0]  operand2;
  logic [1:0]  instr_len;
  logic        ready;

  modport master (
    output Fetch, Decode, Execute,
    output jump_en, jump_addr, rom_data,
    input  rom_addr, pc, Opcode,
    input  operand1, operand2,
    input  instr_len, ready
  );

  modport slave (
    input  Fetch, Decode, Execute,
    input  jump_en, jump_addr, rom_data,
    output rom_addr, pc, Opcode,
    output operand1, operand2,
    output instr_len, ready
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: 8051-style fetch/decode/execute byte sequencer.
// Define INSTR_SEQ_MULTICYCLE_EN for multi-cycle Execute timing.
module instr_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic              clock,
  input logic              reset,
  instr_sequencer_if.slave bus
);
  logic [15:0] pc_r;
  logic [15:0] addr_r;
  logic [7:0]  opc_r;
  logic [7:0]  op1_r;
  logic [7:0]  op2_r;
  logic        rdy_r;
  logic        first_r;
  logic [1:0]  len;
  logic        is2;
  logic        is3;
  logic        do_f;
  logic        do_d;
  logic        do_e;
  logic [15:0] nxt_pc;

  always_comb begin
    is3 = 1'b0;
    is2 = (opc_r[4:0] == 5'h01) ||
          (opc_r[4:0] == 5'h11);
    case (opc_r)
      8'h02, 8'h12, 8'h75,
      8'h85, 8'h90: is3 = 1'b1;
      8'h24, 8'h34, 8'h44, 8'h54,
      8'h64, 8'h74, 8'h94,
      8'h05, 8'h15, 8'hE5, 8'hF5,
      8'h40, 8'h50, 8'h60,
      8'h70, 8'h80: is2 = 1'b1;
      default: ;
    endcase
    if (opc_r[7:4] == 4'hB && opc_r[3:2] != 2'b00)
      is3 = 1'b1;
    if (opc_r[7:3] == 5'b01111)
      is2 = 1'b1;
    if (is3)
      len = 2'd3;
    else if (is2)
      len = 2'd2;
    else
      len = 2'd1;
  end

`ifdef INSTR_SEQ_MULTICYCLE_EN
  logic [1:0] cnt_r;
  logic [1:0] extra;

  // extra = machine cycles - 1
  always_comb begin
    extra = 2'd0;
    if (opc_r == 8'hA4 || opc_r == 8'h84)
      extra = 2'd3;
    else if (is3 || (opc_r[4:0] == 5'h01) ||
             (opc_r[4:0] == 5'h11))
      extra = 2'd1;
    else if (opc_r[3:0] == 4'h0 &&
             opc_r[7:4] >= 4'h4 &&
             opc_r[7:4] <= 4'h8)
      extra = 2'd1;
  end
`endif

  assign do_f = bus.Fetch;
  assign do_d = !bus.Fetch && bus.Decode;
  assign do_e = !bus.Fetch && !bus.Decode &&
                bus.Execute;

  assign nxt_pc = bus.jump_en ? bus.jump_addr
                : pc_r + {14'd0, len};

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_r    <= RESET_PC;
      addr_r  <= RESET_PC;
      opc_r   <= 8'h00;
      op1_r   <= 8'h00;
      op2_r   <= 8'h00;
      rdy_r   <= 1'b0;
      first_r <= 1'b0;
`ifdef INSTR_SEQ_MULTICYCLE_EN
      cnt_r   <= 2'd0;
`endif
    end else begin
      unique case (1'b1)
        do_f: begin
          opc_r   <= bus.rom_data;
          op1_r   <= 8'h00;
          op2_r   <= 8'h00;
          addr_r  <= pc_r + 16'd1;
          rdy_r   <= 1'b0;
          first_r <= 1'b0;
`ifdef INSTR_SEQ_MULTICYCLE_EN
          cnt_r   <= 2'd0;
`endif
        end
        do_d: begin
          if (len != 2'd1) begin
            op1_r  <= bus.rom_data;
            addr_r <= pc_r + 16'd2;
          end
          first_r <= 1'b1;
`ifdef INSTR_SEQ_MULTICYCLE_EN
          if (extra == 2'd0)
            rdy_r <= 1'b1;
          else
            cnt_r <= extra;
`else
          rdy_r <= 1'b1;
`endif
        end
        do_e: begin
          first_r <= 1'b0;
          if (first_r && len == 2'd3)
            op2_r <= bus.rom_data;
          if (rdy_r) begin
            pc_r   <= nxt_pc;
            addr_r <= nxt_pc;
            rdy_r  <= 1'b0;
          end
`ifdef INSTR_SEQ_MULTICYCLE_EN
          else if (cnt_r != 2'd0) begin
            cnt_r <= cnt_r - 2'd1;
            if (cnt_r == 2'd1)
              rdy_r <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr  = addr_r;
  assign bus.pc        = pc_r;
  assign bus.Opcode    = opc_r;
  assign bus.operand1  = op1_r;
  assign bus.operand2  = op2_r;
  assign bus.instr_len = len;
  assign bus.ready     = rdy_r;
endmodule
